ro_ctrl: RTL and testbench

- Readout-path selector for the ETROC1 pixel readout.
- Picks one of four DMRO column data words or the SRO data word and drives the registered result to the serializer-facing output.
- One-cycle registered mux with a source-change strobe, all on a single clock domain.

---
 rtl/ro_ctrl_if.sv | 54 +++++
 rtl/ro_ctrl.sv | 75 +++++++
 tb/tb_ro_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ro_ctrl_if.sv
// rtl/ro_ctrl_if.sv - readout selector signal bundle (select inputs, data words, registered outputs)
interface ro_ctrl_if #(
  parameter int DATA_WIDTH = 30
);

  // Readout mode and DMRO column select
  logic                  RO_SEL;
  logic [1:0]            DMRO_COL;

  // Candidate data words
  logic [DATA_WIDTH-1:0] DataDMRO0;
  logic [DATA_WIDTH-1:0] DataDMRO1;
  logic [DATA_WIDTH-1:0] DataDMRO2;
  logic [DATA_WIDTH-1:0] DataDMRO3;
  logic [DATA_WIDTH-1:0] DataSRO;

  // Registered results toward the serializer
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  SelChanged;
`ifdef RO_CTRL_PARITY_EN
  logic                  DataParity;
`endif

`ifdef RO_CTRL_PARITY_EN
  // Upstream side: drives selects and data, observes the registered word
  modport master (
    output RO_SEL, DMRO_COL,
    output DataDMRO0, DataDMRO1, DataDMRO2, DataDMRO3, DataSRO,
    input  DataOut, SelChanged, DataParity
  );

  // Selector side
  modport slave (
    input  RO_SEL, DMRO_COL,
    input  DataDMRO0, DataDMRO1, DataDMRO2, DataDMRO3, DataSRO,
    output DataOut, SelChanged, DataParity
  );
`else
  // Upstream side: drives selects and data, observes the registered word
  modport master (
    output RO_SEL, DMRO_COL,
    output DataDMRO0, DataDMRO1, DataDMRO2, DataDMRO3, DataSRO,
    input  DataOut, SelChanged
  );

  // Selector side
  modport slave (
    input  RO_SEL, DMRO_COL,
    input  DataDMRO0, DataDMRO1, DataDMRO2, DataDMRO3, DataSRO,
    output DataOut, SelChanged
  );
`endif

endinterface

// File: rtl/ro_ctrl.sv
// rtl/ro_ctrl.sv - ETROC1 readout-path selector: registered DMRO/SRO mux with source-change strobe; optional parity via RO_CTRL_PARITY_EN
module ro_ctrl #(
  parameter int DATA_WIDTH = 30
) (
  input logic        clock,
  input logic        reset,
  ro_ctrl_if.slave   bus
);

  // Source IDs: 0..3 are DMRO columns, 4 is SRO
  localparam logic [2:0] SRC_SRO = 3'd4;

  logic [2:0]            w_src;
  logic [DATA_WIDTH-1:0] w_data;

  logic [DATA_WIDTH-1:0] r_data;
  logic [2:0]            r_src_prev;
  logic                  r_sel_changed;

  // Effective source: DMRO_COL is irrelevant while SRO is selected, so it
  // cannot cause a strobe in that mode
  always_comb begin
    w_src = 3'd0;
    if (bus.RO_SEL) begin
      w_src = SRC_SRO;
    end else begin
      w_src = {1'b0, bus.DMRO_COL};
    end
  end

  // Data word of the effective source, sampled at the same edge as the select
  always_comb begin
    w_data = '0;
    case (w_src)
      3'd0:    w_data = bus.DataDMRO0;
      3'd1:    w_data = bus.DataDMRO1;
      3'd2:    w_data = bus.DataDMRO2;
      3'd3:    w_data = bus.DataDMRO3;
      default: w_data = bus.DataSRO;
    endcase
  end

  // Capture selected word and track source changes; reset forces column 0 as
  // the previous source so release with any other selection strobes once
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data        <= '0;
      r_src_prev    <= 3'd0;
      r_sel_changed <= 1'b0;
    end else begin
      r_data        <= w_data;
      r_src_prev    <= w_src;
      r_sel_changed <= (w_src != r_src_prev);
    end
  end

  assign bus.DataOut    = r_data;
  assign bus.SelChanged = r_sel_changed;

`ifdef RO_CTRL_PARITY_EN
  logic r_parity;

  // Even parity over the captured word, registered in step with DataOut
  always_ff @(posedge clock) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ^w_data;
    end
  end

  assign bus.DataParity = r_parity;
`endif

endmodule

// File: tb/tb_ro_ctrl.sv
// tb/tb_ro_ctrl.sv - self-checking bench for ro_ctrl (vector table plus multi-cycle sequences)
module tb_ro_ctrl;

  localparam int DW = 30;

  logic clk;
  logic rst;

  ro_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  ro_ctrl #(.DATA_WIDTH(DW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          sel;
    logic [1:0]    col;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] d3;
    logic [DW-1:0] sro;
    logic [DW-1:0] exp_data;
    logic          exp_chg;
  } vec_t;

  vec_t vecs [12];

  int total;
  int bad;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock one edge, check outputs 1 time unit later
  task automatic apply(input string name, input logic r, input logic sel, input logic [1:0] col,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                       input logic [DW-1:0] sro,
                       input logic [DW-1:0] exp_data, input logic exp_chg);
    rst           = r;
    bus.RO_SEL    = sel;
    bus.DMRO_COL  = col;
    bus.DataDMRO0 = d0;
    bus.DataDMRO1 = d1;
    bus.DataDMRO2 = d2;
    bus.DataDMRO3 = d3;
    bus.DataSRO   = sro;
    @(posedge clk);
    #1;
    check({name, ".data"}, bus.DataOut, exp_data);
    check({name, ".chg"}, {{(DW-1){1'b0}}, bus.SelChanged}, {{(DW-1){1'b0}}, exp_chg});
`ifdef RO_CTRL_PARITY_EN
    check({name, ".par"}, {{(DW-1){1'b0}}, bus.DataParity}, {{(DW-1){1'b0}}, ^exp_data});
`endif
  endtask

  logic [2:0]    prev_src;
  logic [2:0]    src;
  logic [1:0]    col;
  logic [DW-1:0] v0, v1, v2, v3, vs, ex;
  int            strobes;

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.RO_SEL = 1'b0;
    bus.DMRO_COL = 2'd0;
    bus.DataDMRO0 = '0;
    bus.DataDMRO1 = '0;
    bus.DataDMRO2 = '0;
    bus.DataDMRO3 = '0;
    bus.DataSRO = '0;

    //          rst   sel   col   d0        d1        d2        d3        sro           exp_data      chg
    vecs[0]  = '{1'b1, 1'b1, 2'd3, 30'h0AA, 30'h0BB, 30'h0CC, 30'h0DD, 30'h3FFFFFFF, 30'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 30'h0AA, 30'h0BB, 30'h0CC, 30'h0DD, 30'h0EE,      30'h0,        1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 30'h0AA, 30'h0BB, 30'h0CC, 30'h0DD, 30'h0EE,      30'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 30'h111, 30'h222, 30'h333, 30'h444, 30'h555,      30'h111,      1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'd1, 30'h112, 30'h222, 30'h334, 30'h445, 30'h556,      30'h222,      1'b1};
    vecs[5]  = '{1'b0, 1'b0, 2'd1, 30'h113, 30'h223, 30'h335, 30'h446, 30'h557,      30'h223,      1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'd1, 30'h114, 30'h224, 30'h336, 30'h447, 30'h3FFFFFFF, 30'h3FFFFFFF, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 2'd3, 30'h115, 30'h225, 30'h337, 30'h448, 30'h0,        30'h0,        1'b0};
    vecs[8]  = '{1'b0, 1'b0, 2'd2, 30'h116, 30'h226, 30'h555, 30'h449, 30'h1,        30'h555,      1'b1};
    vecs[9]  = '{1'b1, 1'b0, 2'd2, 30'h117, 30'h227, 30'h556, 30'h44A, 30'h2,        30'h0,        1'b0};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 30'h118, 30'h228, 30'h557, 30'h44B, 30'h3,        30'h557,      1'b1};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 30'h1,   30'h229, 30'h558, 30'h44C, 30'h4,        30'h1,        1'b1};

    for (int i = 0; i < 12; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].sel, vecs[i].col,
            vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].sro,
            vecs[i].exp_data, vecs[i].exp_chg);
    end
    prev_src = 3'd0;

    // All-ones on column 0: parity of the captured word is even (0)
    apply("ones", 1'b0, 1'b0, 2'd0, 30'h3FFFFFFF, 30'h0, 30'h0, 30'h0, 30'h0, 30'h3FFFFFFF, 1'b0);

    // DMRO sweep: counting columns, column steps every 12 cycles
    strobes = 0;
    for (int k = 0; k < 72; k++) begin
      v0 = 30'(0    + 3*k);
      v1 = 30'(2000 + 3*k);
      v2 = 30'(4000 + 3*k);
      v3 = 30'(8000 + 3*k);
      vs = 30'(k);
      case ((k / 12) % 4)
        0: begin col = 2'd0; ex = v0; end
        1: begin col = 2'd1; ex = v1; end
        2: begin col = 2'd2; ex = v2; end
        default: begin col = 2'd3; ex = v3; end
      endcase
      src = {1'b0, col};
      if (src != prev_src) strobes = strobes + 1;
      apply($sformatf("sweep%0d", k), 1'b0, 1'b0, col, v0, v1, v2, v3, vs, ex, src != prev_src);
      prev_src = src;
    end
    check("sweep_strobes", 30'(strobes), 30'd5);

    // SRO select from DMRO column 1: one strobe, then follows DataSRO
    for (int k = 0; k < 10; k++) begin
      vs = 30'(20000 + 3*k);
      apply($sformatf("sro%0d", k), 1'b0, 1'b1, 2'd1, 30'h7, 30'h8, 30'h9, 30'hA, vs, vs, k == 0);
    end

    // Column changes under SRO raise no strobe
    for (int k = 0; k < 4; k++) begin
      vs = 30'(20030 + 3*k);
      apply($sformatf("sro_col%0d", k), 1'b0, 1'b1, 2'(k), 30'h7, 30'h8, 30'h9, 30'hA, vs, vs, 1'b0);
    end

    // Mid-stream reset while streaming column 2
    apply("c2_a", 1'b0, 1'b0, 2'd2, 30'h1, 30'h2, 30'd4100, 30'h4, 30'h5, 30'd4100, 1'b1);
    apply("c2_b", 1'b0, 1'b0, 2'd2, 30'h1, 30'h2, 30'd4103, 30'h4, 30'h5, 30'd4103, 1'b0);
    apply("c2_rst", 1'b1, 1'b0, 2'd2, 30'h1, 30'h2, 30'd4106, 30'h4, 30'h5, 30'd0, 1'b0);
    apply("c2_rel", 1'b0, 1'b0, 2'd2, 30'h1, 30'h2, 30'd4109, 30'h4, 30'h5, 30'd4109, 1'b1);
    apply("c2_c", 1'b0, 1'b0, 2'd2, 30'h1, 30'h2, 30'd4112, 30'h4, 30'h5, 30'd4112, 1'b0);

    // Parity corner words on column 0
    apply("par_ones", 1'b0, 1'b0, 2'd0, 30'h3FFFFFFF, 30'h0, 30'h0, 30'h0, 30'h0, 30'h3FFFFFFF, 1'b1);
    apply("par_one", 1'b0, 1'b0, 2'd0, 30'h00000001, 30'h0, 30'h0, 30'h0, 30'h0, 30'h00000001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
